oam_dma: RTL and testbench
==========================

# oam_dma

Sprite DMA controller that sequences the shared CPU/RAM bus. A CPU write of page value P to the DMA register stalls the CPU via `rdy`, takes the bus, and copies 256 bytes from P00–PFF to the sprite data port one byte per read/write pair. It then returns the bus to the CPU. It sits between the `cpu` core and the system bus (RAM, PPU), and owns the address/rw/write-data mux.

## Interface
Parameters:
- `REG_ADDR`, 16'h4014: CPU write address that triggers DMA.
- `DEST_ADDR`, 16'h2004: destination address for every DMA write.
- `LENGTH`, 256: bytes per transfer; power of two, at most 256.

Ports:
- `clk`  in  1: system clock. One clock, rising edge.
- `n_reset`  in  1: reset, asynchronous, active-low.
- `cpu_addr`  in  16: CPU bus address.
- `cpu_rw`  in  1: CPU direction; 1 = read.
- `cpu_dout`  in  8: CPU write data.
- `bus_din`  in  8: read data returned from the bus.
- `addr`  out  16: bus address after the mux.
- `rw`  out  1: bus direction after the mux.
- `dout`  out  8: bus write data after the mux.
- `rdy`  out  1: CPU ready; 0 stalls the CPU on its next read.
- `active`  out  1: DMA owns the bus.

## Operation
- **States:** IDLE, HALT, ALIGN, READ, WRITE.
- **Registers:**
  - `page` (8): latched source page.
  - `cnt` (8): byte index.
  - `byte` (8): data buffer.
  - `par` (1): cycle parity; toggles every `clk` from reset 0.
- **IDLE:**
  - On a posedge with `cpu_rw`=0 and `cpu_addr`==`REG_ADDR`: latch `page`<=`cpu_dout`, `cnt`<=0, go to HALT.
  - Otherwise stay in IDLE.
- **HALT:**
  - `rdy`=0. The bus still follows the CPU.
  - If `cpu_rw`=1, go to ALIGN. Otherwise stay, because the CPU cannot stall on a write.
- **ALIGN:**
  - `rdy`=0, `active`=1. Dummy cycle: `addr`=`cpu_addr`, `rw`=1.
  - If `par`=1 on entry, spend one extra ALIGN cycle. Then go to READ.
- **READ:**
  - `addr`={`page`,`cnt`}, `rw`=1.
  - `byte`<=`bus_din` at the closing edge. Go to WRITE.
- **WRITE:**
  - `addr`=`DEST_ADDR`, `rw`=0, `dout`=`byte`.
  - `cnt`<=`cnt`+1 (mod 256).
  - If `cnt`==`LENGTH`-1, go to IDLE; otherwise go to READ.
- **Mux:**
  - When `active`=0: `addr`/`rw`/`dout` = `cpu_addr`/`cpu_rw`/`cpu_dout`.
  - `active`=1 in ALIGN, READ and WRITE only.
- `rdy`=0 in HALT, ALIGN, READ and WRITE. `rdy`=1 in IDLE.
- A `REG_ADDR` write while the controller is not in IDLE is ignored.
- A CPU write to `DEST_ADDR` while in IDLE passes through unmodified.

## Timing
- **Reset values:**
  - State IDLE; `page`, `cnt`, `byte` = 0; `par`=0.
  - `rdy`=1, `active`=0; `addr`/`rw`/`dout` follow the CPU inputs combinationally.
- All state changes happen on the rising edge of `clk`. Outputs are combinational from state and registers.
- **Latency:** the trigger write is at cycle T, and `rdy` falls in cycle T+1.
- **Length:** with an immediate read in HALT, `rdy` stays low for 1 + 1 + `par` + 2·`LENGTH` cycles. That is 514 cycles (par=0) or 515 cycles (par=1) for `LENGTH`=256.
- `rdy` returns to 1 in the cycle after the final WRITE.
- **Address wrap:** the source address wraps within the page (`cnt` 8-bit). It never carries into `page`.
- **Reset mid-transfer:** asynchronous return to IDLE. `rdy`=1 and `active`=0 immediately. The partial copy is abandoned.
- **Back-to-back transfers:** a `REG_ADDR` write in the first cycle after a transfer finishes starts a new transfer normally.

## Structure
- **Shared package `dma_pkg`:**
  - `dma_state_t` enum (IDLE, HALT, ALIGN, READ, WRITE).
  - Defaults `OAM_DMA_REG` = 16'h4014 and `OAM_DATA` = 16'h2004.
- **Sub-module `bus_mux`:** the combinational 3-signal 2:1 mux, selected by `active`. It is reused later for APU DMC DMA.
- The FSM, counter and parity register live in `oam_dma`.

## Test plan
- **Basic copy:**
  - Stimulus: RAM 0x0200–0x02FF preloaded with the value i at address 0x0200+i; CPU writes 8'h02 to 4014 with `par`=0.
  - Required: exactly 256 writes to 2004 with data 0x00..0xFF in order; `rdy` low for 514 cycles.
- **Odd parity:** same stimulus, with the trigger timed so `par`=1 at ALIGN entry -> `rdy` low for 515 cycles, and the first READ is one cycle later than in the even case.
- **Write hold:** CPU issues two more writes after the trigger -> the controller stays in HALT; `active`=0 and the CPU writes reach the bus; ALIGN starts on the first `cpu_rw`=1.
- **Mid-transfer reset:**
  - Stimulus: `n_reset` pulsed low after 100 WRITEs.
  - Required: `rdy`=1 and `active`=0 within the same cycle; no further writes to 2004; a new trigger afterwards copies a full 256 bytes.
- **Pass-through:** in IDLE, CPU read of 0x1234 and write 0xAB to 0x2004 -> `addr`, `rw` and `dout` equal the CPU values; `rdy` stays 1.
- **Ignored retrigger:** a forced `REG_ADDR` write during READ/WRITE -> `page` is unchanged and the transfer length stays 256.

Source files
------------

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared DMA state encoding and default bus addresses
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_t;

  localparam logic [15:0] OAM_DMA_REG = 16'h4014;
  localparam logic [15:0] OAM_DATA    = 16'h2004;

endpackage

// File: rtl/bus_mux.sv
// rtl/bus_mux.sv - 2:1 select of address/rw/write-data between CPU and a DMA master
module bus_mux (
  input  logic        sel,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_dout,
  input  logic [15:0] dma_addr,
  input  logic        dma_rw,
  input  logic [7:0]  dma_dout,
  output logic [15:0] addr,
  output logic        rw,
  output logic [7:0]  dout
);

  assign addr = sel ? dma_addr : cpu_addr;
  assign rw   = sel ? dma_rw   : cpu_rw;
  assign dout = sel ? dma_dout : cpu_dout;

endmodule

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - sprite DMA: stalls the CPU and copies one page to the sprite data port
module oam_dma
  import dma_pkg::*;
#(
  parameter logic [15:0] REG_ADDR  = OAM_DMA_REG,
  parameter logic [15:0] DEST_ADDR = OAM_DATA,
  parameter int          LENGTH    = 256
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_dout,
  input  logic [7:0]  bus_din,
  output logic [15:0] addr,
  output logic        rw,
  output logic [7:0]  dout,
  output logic        rdy,
  output logic        active
);

  localparam logic [7:0] LAST_CNT = 8'(LENGTH - 1);

  dma_state_t  state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        par_q, par_d;
  logic [15:0] dma_addr;
  logic        dma_rw;

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    par_d   = ~par_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!cpu_rw && cpu_addr == REG_ADDR) begin
          page_d  = cpu_dout;
          cnt_d   = 8'd0;
          state_d = ST_HALT;
        end
      end
      // The CPU only honours rdy on a read, so keep waiting through its writes.
      ST_HALT:  if (cpu_rw) state_d = ST_ALIGN;
      // Leaving only on even parity makes every READ land on an odd cycle.
      ST_ALIGN: if (!par_q) state_d = ST_READ;
      ST_READ: begin
        byte_d  = bus_din;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        cnt_d   = cnt_q + 8'd1;
        state_d = (cnt_q == LAST_CNT) ? ST_IDLE : ST_READ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_IDLE;
      page_q  <= 8'd0;
      cnt_q   <= 8'd0;
      byte_q  <= 8'd0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    dma_addr = cpu_addr;
    dma_rw   = 1'b1;
    case (state_q)
      ST_READ:  dma_addr = {page_q, cnt_q};
      ST_WRITE: begin
        dma_addr = DEST_ADDR;
        dma_rw   = 1'b0;
      end
      default: ;
    endcase
  end

  assign rdy    = (state_q == ST_IDLE);
  assign active = (state_q == ST_ALIGN) || (state_q == ST_READ) || (state_q == ST_WRITE);

  bus_mux u_bus_mux (
    .sel      (active),
    .cpu_addr (cpu_addr),
    .cpu_rw   (cpu_rw),
    .cpu_dout (cpu_dout),
    .dma_addr (dma_addr),
    .dma_rw   (dma_rw),
    .dma_dout (byte_q),
    .addr     (addr),
    .rw       (rw),
    .dout     (dout)
  );

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - scoreboard bench for oam_dma
module tb_oam_dma;

  typedef struct {
    logic [15:0] raddr;
    logic [7:0]  data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_dout;
  logic [7:0]  bus_din;
  logic [15:0] addr;
  logic        rw;
  logic [7:0]  dout;
  logic        rdy;
  logic        active;

  int   errors = 0;
  int   checks = 0;
  int   edges;
  int   wr_seen = 0;
  int   lo_cnt = 0;
  exp_t exp_q[$];
  int   len_q[$];
  exp_t mon_e;

  oam_dma dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .cpu_addr (cpu_addr),
    .cpu_rw   (cpu_rw),
    .cpu_dout (cpu_dout),
    .bus_din  (bus_din),
    .addr     (addr),
    .rw       (rw),
    .dout     (dout),
    .rdy      (rdy),
    .active   (active)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem(input logic [15:0] a);
    if (a[15:8] == 8'h02) return a[7:0];
    if (a[15:8] == 8'h03) return ~a[7:0];
    return a[15:8] ^ a[7:0];
  endfunction

  assign bus_din = mem(addr);

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) edges <= 0;
    else          edges <= edges + 1;
  end

  // Monitor: DMA bus cycles against the scoreboard, rdy-low spans against len_q.
  always @(negedge clk) begin
    if (n_reset && active) begin
      if (!rw) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %h dout %h at %0t", addr, dout, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", 32'(addr), 32'h2004);
          chk("wr_data", 32'(dout), 32'(mon_e.data));
          chk("wr_cycle", edges, mon_e.cyc);
          wr_seen++;
        end
      end else if (addr != cpu_addr) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: addr %h at %0t", addr, $time);
        end else begin
          chk("rd_addr", 32'(addr), 32'(exp_q[0].raddr));
        end
      end
    end
    if (!n_reset) lo_cnt = 0;
    else if (!rdy) lo_cnt++;
    else if (lo_cnt != 0) begin
      if (len_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_stall: %0d cycles", lo_cnt);
      end else begin
        chk("rdy_low_len", lo_cnt, len_q.pop_front());
      end
      lo_cnt = 0;
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(posedge clk); #1;
    while (!rdy && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: rdy %0b required 1", rdy);
    end
  endtask

  // want_par: 0 or 1 forces parity at ALIGN entry, 2 accepts whatever comes.
  task automatic trigger(input logic [7:0] pg, input int nwr, input int want_par);
    int e;
    int p;
    wait_idle();
    if (want_par != 2 && ((edges + nwr) % 2) != want_par) begin
      @(posedge clk); #1;
    end
    e = edges;
    p = (e + nwr) % 2;
    for (int k = 0; k < 256; k++) begin
      exp_q.push_back('{raddr: {pg, 8'(k)}, data: mem({pg, 8'(k)}), cyc: e + 4 + nwr + p + 2 * k});
    end
    len_q.push_back(514 + nwr + p);
    cpu_addr = 16'h4014;
    cpu_rw   = 1'b0;
    cpu_dout = pg;
    for (int i = 0; i < nwr; i++) begin
      @(posedge clk); #1;
      cpu_addr = 16'h0010 + 16'(i);
      cpu_rw   = 1'b0;
      cpu_dout = 8'h5A ^ 8'(i);
      @(negedge clk);
      chk("hold_active", 32'(active), 32'd0);
      chk("hold_rdy", 32'(rdy), 32'd0);
      chk("hold_addr", 32'(addr), 32'h0010 + i);
      chk("hold_rw", 32'(rw), 32'd0);
      chk("hold_dout", 32'(dout), 32'(8'h5A ^ 8'(i)));
    end
    @(posedge clk); #1;
    cpu_addr = 16'h8000;
    cpu_rw   = 1'b1;
    cpu_dout = 8'h00;
  endtask

  task automatic final_check(input string name);
    wait_idle();
    @(negedge clk); #1;
    chk({name, "_exp_left"}, exp_q.size(), 0);
    chk({name, "_len_left"}, len_q.size(), 0);
  endtask

  initial begin
    int base;
    int n;
    n_reset  = 1'b0;
    cpu_addr = 16'h1234;
    cpu_rw   = 1'b1;
    cpu_dout = 8'h77;
    #3;
    chk("rst_rdy", 32'(rdy), 32'd1);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_addr", 32'(addr), 32'h1234);
    chk("rst_dout", 32'(dout), 32'h77);
    repeat (2) @(posedge clk);
    #1 n_reset = 1'b1;

    @(posedge clk); #1;
    cpu_addr = 16'h1234; cpu_rw = 1'b1; cpu_dout = 8'h00;
    @(negedge clk);
    chk("pt_rd_addr", 32'(addr), 32'h1234);
    chk("pt_rd_rw", 32'(rw), 32'd1);
    chk("pt_rd_rdy", 32'(rdy), 32'd1);
    @(posedge clk); #1;
    cpu_addr = 16'h2004; cpu_rw = 1'b0; cpu_dout = 8'hAB;
    @(negedge clk);
    chk("pt_wr_addr", 32'(addr), 32'h2004);
    chk("pt_wr_rw", 32'(rw), 32'd0);
    chk("pt_wr_dout", 32'(dout), 32'hAB);
    chk("pt_wr_active", 32'(active), 32'd0);
    @(posedge clk); #1;
    cpu_addr = 16'h8000; cpu_rw = 1'b1; cpu_dout = 8'h00;
    @(negedge clk);
    chk("pt_after_rdy", 32'(rdy), 32'd1);

    trigger(8'h02, 0, 0);
    final_check("basic");

    trigger(8'h02, 0, 1);
    final_check("odd");

    trigger(8'h03, 2, 2);
    trigger(8'h02, 0, 2);
    final_check("hold_b2b");

    trigger(8'h02, 0, 0);
    repeat (50) @(posedge clk);
    #1;
    cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_dout = 8'h05;
    @(posedge clk); #1;
    cpu_addr = 16'h8000; cpu_rw = 1'b1; cpu_dout = 8'h00;
    final_check("retrig");

    base = wr_seen;
    trigger(8'h03, 0, 2);
    n = 0;
    while (wr_seen < base + 100 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    n_reset = 1'b0;
    exp_q.delete();
    len_q.delete();
    #1;
    chk("mrst_rdy", 32'(rdy), 32'd1);
    chk("mrst_active", 32'(active), 32'd0);
    chk("mrst_addr", 32'(addr), 32'h8000);
    chk("mrst_writes", wr_seen - base, 100);
    @(negedge clk);
    @(posedge clk); #1;
    n_reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("mrst_idle_rdy", 32'(rdy), 32'd1);
    base = wr_seen;
    trigger(8'h02, 0, 0);
    final_check("after_rst");
    chk("after_rst_count", wr_seen - base, 256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
